hash_update_rr_sched: RTL and testbench
=======================================

Name: hash_update_rr_sched

Overview:
Round-robin scheduler that shares one hash-table update port between 16 hash-update lanes.
- Picks one valid lane per cycle and drives the 5-bit select of the 16:1 128-bit hash-update mux.
- Captures the mux output into a single-entry output register.
- Presents that entry to the hash bank with a valid/ready handshake.
- Sits between the per-lane hash generators and the hash-table write port.

Parameters:
NUM_REQ, 16, number of requesting lanes (fixed at 16; mux width).
DATA_W, 128, update word width.
SEL_W, 5, mux select width; value 16 selects the mux default (all-zero output).

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  16  per-lane update request; bit i pairs with mux input din i.
req_ready  out  16  one-hot grant; lane i's word is taken this cycle when req_valid[i] && req_ready[i].
mux_sel  out  5  select to the 16:1 hash-update mux.
mux_dout  in  128  mux output, fed back combinationally.
upd_valid  out  1  output entry valid.
upd_data  out  128  update word to the hash bank.
upd_src  out  4  lane index that produced upd_data.
upd_ready  in  1  hash bank accepts the entry.
idle  out  1  high when no entry is held and req_valid == 0.

Behaviour:
Clock and reset:
- Single clock domain on clk.
- rst is asynchronous, active-high.

Reset values:
- upd_valid=0, upd_data=0, upd_src=0.
- Internal rr_ptr[3:0]=0.
- Combinational outputs during reset: req_ready=0, mux_sel=16, idle=1 (provided req_valid=0).

Load condition:
- load = !upd_valid || upd_ready.

Arbitration (combinational):
- Only when load is true.
- Search req_valid starting at index rr_ptr, ascending, wrapping 15→0; the first set bit wins (index w).
- If a winner exists: req_ready = one-hot(w), mux_sel = {1'b0, w}.
- Otherwise, or when load is false: req_ready=0, mux_sel=16.

Register update on each clk edge when load is true:
- Winner exists: upd_valid<=1, upd_data<=mux_dout, upd_src<=w, rr_ptr<=(w+1) mod 16.
- No winner: upd_valid<=0; upd_data and upd_src hold; rr_ptr holds.

When load is false (upd_valid && !upd_ready):
- All registers hold.
- No grant is issued.

Latency and throughput:
- 1 cycle from grant to upd_valid.
- Sustained 1 update/cycle while upd_ready=1.
- A hand-off (upd_valid && upd_ready) and a new grant in the same cycle is legal and required; no bubble.

Fairness:
- rr_ptr advances only on a grant.
- A continuously asserted lane is granted within 16 grants.

Requester protocol:
- A lane holds req_valid and its data stable until granted.
- A lane may raise req_valid at any time.
- Dropping req_valid before grant is a protocol violation; it is not checked.

Other rules:
- upd_data and upd_src are stable while upd_valid && !upd_ready.
- mux_dout is sampled only in a grant cycle.
- Asserting rst mid-operation discards the held entry immediately; no partial state survives.
- idle is combinational: !upd_valid && (req_valid==0).

Decomposition:
- Shared package hash_upd_pkg:
  - constants HU_NUM_LANES=16, HU_DATA_W=128, HU_SEL_W=5, HU_SEL_NONE=5'd16;
  - typedef hu_lane_t (logic [3:0]) and hu_word_t (logic [127:0]).
- One natural sub-module, rr_pick16: combinational rotate-priority-encoder (req_valid, rr_ptr → found, w).
- The 16:1 mux stays outside; this block only drives its select.

Test Plan:
1. Reset: hold rst=1 with req_valid=0xFFFF → req_ready=0, mux_sel=16, upd_valid=0, upd_data=0. Release with req_valid=0 → idle=1.
2. Single lane: upd_ready=1, req_valid=0x0020, mux_dout=0xA5..A5 → same cycle req_ready=0x0020, mux_sel=5. Next cycle upd_valid=1, upd_data=0xA5..A5, upd_src=5; then lane 5 dropped → following cycle upd_valid=0, idle=1.
3. Full contention: req_valid=0xFFFF held, upd_ready=1 from reset → upd_src sequence 0,1,2,…,15,0,1 on consecutive cycles, no bubbles.
4. Backpressure: upd_valid=1 with upd_src=3 and upd_ready=0 for 4 cycles, req_valid=0x0100 → req_ready=0, mux_sel=16, upd_data unchanged. On the cycle upd_ready=1 → req_ready=0x0100 same cycle; next cycle upd_src=8.
5. Wrap-around: after a grant to lane 13 (rr_ptr=14), req_valid=0x8002 → grant 15 first, then 1; rr_ptr=2 afterward.
6. Async reset mid-stream: req_valid=0xFFFF, upd_valid=1; assert rst between edges → upd_valid=0 without waiting for a clock edge. After release, first grant goes to lane 0.

Source files
------------

// File: rtl/hash_upd_pkg.sv
// Shared constants and types for the hash-update round-robin scheduler.
package hash_upd_pkg;

    localparam int unsigned HU_NUM_LANES = 16;
    localparam int unsigned HU_DATA_W    = 128;
    localparam int unsigned HU_SEL_W     = 5;

    // A select value of 16 picks the mux default input, which outputs all zeros.
    localparam logic [HU_SEL_W-1:0] HU_SEL_NONE = 5'd16;

    typedef logic [3:0]           hu_lane_t;
    typedef logic [HU_DATA_W-1:0] hu_word_t;

endpackage : hash_upd_pkg

// File: rtl/rr_pick16.sv
// Rotating-priority encoder: finds the first set request at or after the
// pointer, wrapping from lane 15 back to lane 0.
module rr_pick16
    import hash_upd_pkg::*;
(
    input  logic [HU_NUM_LANES-1:0] i_req,
    input  hu_lane_t                i_ptr,
    output logic                    o_found,
    output hu_lane_t                o_win
);

    hu_lane_t w_idx;

    // Scan from the farthest offset down to the pointer so the nearest request wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_found = 1'b0;
        o_win   = i_ptr;
        w_idx   = i_ptr;
        for (int k = HU_NUM_LANES - 1; k >= 0; k--) begin
            // The 4-bit sum wraps naturally, giving the 15 -> 0 rotation.
            w_idx = i_ptr + hu_lane_t'(k);
            if (i_req[w_idx]) begin
                o_found = 1'b1;
                o_win   = w_idx;
            end
        end
    end

endmodule : rr_pick16

// File: rtl/hash_update_rr_sched.sv
// Round-robin scheduler sharing one hash-table update port among 16 lanes.
// Drives the select of an external 16:1 mux, captures its output into a
// single-entry register and offers it to the hash bank with valid/ready.
module hash_update_rr_sched
    import hash_upd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [HU_NUM_LANES-1:0] i_req_valid,
    output logic [HU_NUM_LANES-1:0] o_req_ready,
    output logic [HU_SEL_W-1:0]     o_mux_sel,
    input  hu_word_t                i_mux_dout,
    output logic                    o_upd_valid,
    output hu_word_t                o_upd_data,
    output hu_lane_t                o_upd_src,
    input  logic                    i_upd_ready,
    output logic                    o_idle
);

    logic     r_upd_valid;
    hu_word_t r_upd_data;
    hu_lane_t r_upd_src;
    hu_lane_t r_rr_ptr;

    logic     w_load;
    logic     w_found;
    hu_lane_t w_win;
    logic     w_grant;

    rr_pick16 u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_win   (w_win)
    );

    // The entry can be refilled when it is empty or being handed off this cycle,
    // which lets a hand-off and a new grant share a cycle with no bubble.
    assign w_load = !r_upd_valid || i_upd_ready;

    // Grants are suppressed while reset is asserted so no lane believes it was taken.
    assign w_grant = !rst && w_load && w_found;

    // Present the one-hot grant and the matching mux select.
    always_comb begin
        o_req_ready = '0;
        o_mux_sel   = HU_SEL_NONE;
        if (w_grant) begin
            o_req_ready = HU_NUM_LANES'(1) << w_win;
            o_mux_sel   = {1'b0, w_win};
        end
    end

    // Capture the granted word, or drain the entry when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_upd_valid <= 1'b0;
            r_upd_data  <= '0;
            r_upd_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_upd_valid <= 1'b1;
                r_upd_data  <= i_mux_dout;
                r_upd_src   <= w_win;
                r_rr_ptr    <= w_win + hu_lane_t'(1);
            end else begin
                r_upd_valid <= 1'b0;
            end
        end
    end

    assign o_upd_valid = r_upd_valid;
    assign o_upd_data  = r_upd_data;
    assign o_upd_src   = r_upd_src;
    assign o_idle      = !r_upd_valid && (i_req_valid == '0);

endmodule : hash_update_rr_sched

// File: tb/tb_hash_update_rr_sched.sv
// Directed bench for the hash-update round-robin scheduler.
`timescale 1ns/1ps
module tb_hash_update_rr_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  req_valid;
    logic [15:0]  req_ready;
    logic [4:0]   mux_sel;
    logic [127:0] mux_dout;
    logic         upd_valid;
    logic [127:0] upd_data;
    logic [3:0]   upd_src;
    logic         upd_ready;
    logic         idle;

    logic [127:0] tb_dout;
    logic         use_model;
    logic [127:0] din [16];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] W_A5   = {16{8'hA5}};
    localparam logic [127:0] W_D1   = {4{32'h1111_0001}};
    localparam logic [127:0] W_D2   = {4{32'h2222_0002}};
    localparam logic [127:0] W_D3   = {4{32'h3333_0003}};
    localparam logic [127:0] W_D4   = {4{32'h4444_0004}};
    localparam logic [127:0] W_D5   = {4{32'h5555_0005}};
    localparam logic [127:0] W_JUNK = {4{32'hDEAD_BEEF}};

    always #5 clk = ~clk;

    // External 16:1 mux model: either a directly driven word or lane data by select.
    always_comb begin
        mux_dout = tb_dout;
        if (use_model) mux_dout = (mux_sel < 5'd16) ? din[mux_sel[3:0]] : '0;
    end

    hash_update_rr_sched dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .o_mux_sel   (mux_sel),
        .i_mux_dout  (mux_dout),
        .o_upd_valid (upd_valid),
        .o_upd_data  (upd_data),
        .o_upd_src   (upd_src),
        .i_upd_ready (upd_ready),
        .o_idle      (idle)
    );

    typedef struct {
        logic [15:0]  req;
        logic         rdy;
        logic [127:0] dout;
        logic [15:0]  x_ready;
        logic [4:0]   x_sel;
        logic         x_valid;
        logic [127:0] x_data;
        logic [3:0]   x_src;
        logic         x_idle;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        upd_ready = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) din[i] = {4{32'hC0DE_0000 | 32'(i)}};

        // Lane 5 alone, then drained; further grants with pointer wrap and backpressure.
        vecs[0] = '{16'h0020, 1'b1, W_A5,   16'h0020, 5'd5,  1'b1, W_A5, 4'd5,  1'b0};
        vecs[1] = '{16'h0000, 1'b1, W_JUNK, 16'h0000, 5'd16, 1'b0, W_A5, 4'd5,  1'b1};
        vecs[2] = '{16'h0001, 1'b1, W_D1,   16'h0001, 5'd0,  1'b1, W_D1, 4'd0,  1'b0};
        vecs[3] = '{16'h8002, 1'b1, W_D2,   16'h0002, 5'd1,  1'b1, W_D2, 4'd1,  1'b0};
        vecs[4] = '{16'h8000, 1'b1, W_D3,   16'h8000, 5'd15, 1'b1, W_D3, 4'd15, 1'b0};
        vecs[5] = '{16'h8001, 1'b0, W_JUNK, 16'h0000, 5'd16, 1'b1, W_D3, 4'd15, 1'b0};
        vecs[6] = '{16'h8001, 1'b1, W_D4,   16'h0001, 5'd0,  1'b1, W_D4, 4'd0,  1'b0};
        vecs[7] = '{16'h8001, 1'b1, W_D5,   16'h8000, 5'd15, 1'b1, W_D5, 4'd15, 1'b0};
        vecs[8] = '{16'h0000, 1'b0, W_JUNK, 16'h0000, 5'd16, 1'b1, W_D5, 4'd15, 1'b0};
        vecs[9] = '{16'h0000, 1'b1, W_JUNK, 16'h0000, 5'd16, 1'b0, W_D5, 4'd15, 1'b1};

        // Reset held with every lane requesting: no grant may leak out.
        use_model = 1'b0;
        tb_dout   = W_JUNK;
        rst       = 1'b1;
        req_valid = 16'hFFFF;
        upd_ready = 1'b1;
        #1;
        check("rst_req_ready", 128'(req_ready), 128'h0);
        check("rst_mux_sel",   128'(mux_sel),   128'd16);
        check("rst_upd_valid", 128'(upd_valid), 128'h0);
        check("rst_upd_data",  upd_data,        128'h0);
        check("rst_upd_src",   128'(upd_src),   128'h0);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("rel_idle", 128'(idle), 128'h1);

        // Table-driven single-lane, wrap and backpressure vectors.
        for (int i = 0; i < 10; i++) begin
            req_valid = vecs[i].req;
            upd_ready = vecs[i].rdy;
            tb_dout   = vecs[i].dout;
            #1;
            check($sformatf("v%0d_req_ready", i), 128'(req_ready), 128'(vecs[i].x_ready));
            check($sformatf("v%0d_mux_sel", i),   128'(mux_sel),   128'(vecs[i].x_sel));
            tick();
            check($sformatf("v%0d_upd_valid", i), 128'(upd_valid), 128'(vecs[i].x_valid));
            check($sformatf("v%0d_upd_data", i),  upd_data,        vecs[i].x_data);
            check($sformatf("v%0d_upd_src", i),   128'(upd_src),   128'(vecs[i].x_src));
            check($sformatf("v%0d_idle", i),      128'(idle),      128'(vecs[i].x_idle));
        end

        // Full contention from reset: lanes in order 0..15,0,1 with no bubbles.
        use_model = 1'b1;
        do_reset();
        req_valid = 16'hFFFF;
        for (int k = 0; k < 18; k++) begin
            #1;
            check($sformatf("cont%0d_req_ready", k), 128'(req_ready), 128'(16'h1 << (k % 16)));
            tick();
            check($sformatf("cont%0d_upd_valid", k), 128'(upd_valid), 128'h1);
            check($sformatf("cont%0d_upd_src", k),   128'(upd_src),   128'(k % 16));
            check($sformatf("cont%0d_upd_data", k),  upd_data,        din[k % 16]);
        end

        // Async reset between edges drops the held entry immediately.
        #1;
        rst = 1'b1;
        #1;
        check("arst_upd_valid", 128'(upd_valid), 128'h0);
        check("arst_upd_data",  upd_data,        128'h0);
        check("arst_req_ready", 128'(req_ready), 128'h0);
        check("arst_mux_sel",   128'(mux_sel),   128'd16);
        rst = 1'b0;
        #1;
        check("arst_first_ready", 128'(req_ready), 128'h1);
        tick();
        check("arst_first_src",   128'(upd_src),   128'h0);
        check("arst_first_valid", 128'(upd_valid), 128'h1);

        // Backpressure: entry from lane 3 held for 4 cycles while lane 8 waits.
        do_reset();
        req_valid = 16'h0008;
        tick();
        check("bp_setup_src", 128'(upd_src), 128'd3);
        req_valid = 16'h0100;
        upd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp%0d_req_ready", k), 128'(req_ready), 128'h0);
            check($sformatf("bp%0d_mux_sel", k),   128'(mux_sel),   128'd16);
            tick();
            check($sformatf("bp%0d_upd_data", k),  upd_data,        din[3]);
            check($sformatf("bp%0d_upd_src", k),   128'(upd_src),   128'd3);
            check($sformatf("bp%0d_upd_valid", k), 128'(upd_valid), 128'h1);
        end
        upd_ready = 1'b1;
        #1;
        check("bp_rel_req_ready", 128'(req_ready), 128'h0100);
        check("bp_rel_mux_sel",   128'(mux_sel),   128'd8);
        tick();
        check("bp_rel_upd_src",  128'(upd_src), 128'd8);
        check("bp_rel_upd_data", upd_data,       din[8]);

        // Wrap-around: after lane 13, lanes 15 then 1, leaving the pointer at 2.
        do_reset();
        req_valid = 16'h2000;
        tick();
        check("wrap_src13", 128'(upd_src), 128'd13);
        req_valid = 16'h8002;
        #1;
        check("wrap_ready15", 128'(req_ready), 128'h8000);
        tick();
        check("wrap_src15", 128'(upd_src), 128'd15);
        req_valid = 16'h0002;
        #1;
        check("wrap_ready1", 128'(req_ready), 128'h0002);
        tick();
        check("wrap_src1", 128'(upd_src), 128'd1);
        // Pointer at 2: lanes 0 and 1 both request, lane 0 is reached first.
        req_valid = 16'h0003;
        #1;
        check("wrap_ptr2_ready", 128'(req_ready), 128'h0001);
        tick();
        check("wrap_ptr2_src", 128'(upd_src), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hash_update_rr_sched
